tick_ring_sequencer: RTL
========================

TICK_RING_SEQUENCER -- requirements
Module: tick_ring_sequencer

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-low reset, named clk and rst_n.
REQ-002 clk  input  1  system clock; all state updates on its rising edge.
REQ-003 rst_n  input  1  asynchronous active-low reset.
REQ-004 dclk  input  1  divided-clock level from the upstream clock divider, synchronous to clk.
REQ-005 start  input  1  begin a run; sampled only in IDLE.
REQ-006 stop  input  1  abort a run; sampled only in RUN.
REQ-007 dir  input  1  rotate direction: 0 = left (bit7 <- bit6, bit0 <- bit7), 1 = right (bit0 <- bit1, bit7 <- bit0).
REQ-008 load  input  1  load pattern from load_val; sampled only in IDLE.
REQ-009 load_val  input  8  pattern value for load.
REQ-010 steps  input  4  run length in ticks; 0 means free-run until stop.
REQ-011 pattern  output  8  current ring pattern, registered.
REQ-012 step_cnt  output  4  ticks consumed in the current run, registered.
REQ-013 busy  output  1  high exactly while the state is RUN.
REQ-014 done  output  1  one-cycle pulse on completion of a bounded run.

Function
REQ-015 tick SHALL be dclk AND NOT dclk_q, where dclk_q is dclk registered on clk; a dclk held high yields exactly one tick.
REQ-016 A tick SHALL update pattern and step_cnt on the same clk edge that first samples dclk high (zero added latency).
REQ-017 The FSM SHALL have states IDLE, RUN and DONE.
REQ-018 IDLE: load=1 SHALL set pattern to load_val; load and start together SHALL load first, with start taking effect on the same edge.
REQ-019 IDLE: start=1 SHALL move to RUN, clear step_cnt to 0 and latch steps into steps_q.
REQ-020 RUN: each tick SHALL rotate pattern per the current dir and increment step_cnt modulo 16.
REQ-021 RUN: on a tick with steps_q != 0 and step_cnt+1 == steps_q, the FSM SHALL move to DONE, keeping the rotated pattern.
REQ-022 RUN: stop=1 SHALL move to IDLE with no done pulse; a tick in the same cycle SHALL be ignored.
REQ-023 RUN with steps_q == 0 SHALL run until stop, with step_cnt wrapping from 15 to 0.
REQ-024 DONE SHALL assert done for exactly one cycle and return to IDLE unconditionally; ticks in DONE SHALL be ignored.
REQ-025 Changes to steps during RUN SHALL have no effect; changes to dir SHALL take effect on the next tick.
REQ-026 pattern and step_cnt SHALL hold their values in IDLE and DONE, except pattern on load.
REQ-027 An all-zero pattern SHALL rotate as all-zero; no error SHALL be flagged.

Reset
REQ-028 Asserting rst_n low SHALL immediately set: state IDLE, pattern 8'b0000_0001, step_cnt 0, steps_q 0, dclk_q 0, busy 0, done 0.
REQ-029 Reset asserted mid-run SHALL abort the run with no done pulse.
REQ-030 After reset release, a dclk that is already high SHALL produce one tick on the first edge.

Structure
REQ-031 The shared package SHALL hold the state encoding (IDLE, RUN, DONE) and the constant PATTERN_RST = 8'b0000_0001.
REQ-032 Rising-edge detection SHALL be a sub-module, tick_edge_detect (ports clk, rst_n, din, pulse).

Verification
REQ-033 Reset, steps=3, dir=0, start, then 3 dclk rising edges -> pattern 02, 04, 08; done pulses once; busy falls; step_cnt=3.
REQ-034 load_val=8'h81 with load in IDLE, dir=1, steps=2, start, 2 ticks -> pattern C0 then 60; done asserted 1 cycle.
REQ-035 steps=0, start, 17 ticks -> step_cnt wraps to 1; pattern 02 (left rotate); stop -> IDLE with no done.
REQ-036 stop coincident with a tick in RUN -> pattern unchanged; state IDLE.
REQ-037 dclk held high for 10 clk cycles in RUN -> exactly one rotation.
REQ-038 rst_n pulsed low mid-run (step_cnt=2, pattern 04) -> immediately pattern 01, step_cnt 0, busy 0, done 0.

Source files
------------

// File: rtl/tick_ring_sequencer_pkg.sv
// Shared constants for the tick-driven ring sequencer: state encoding, reset pattern, rotate helper.
package tick_ring_sequencer_pkg;

    localparam int unsigned PAT_W = 8;
    localparam int unsigned CNT_W = 4;
    localparam int unsigned ST_W  = 2;

    localparam logic [ST_W-1:0] ST_IDLE = 2'd0;
    localparam logic [ST_W-1:0] ST_RUN  = 2'd1;
    localparam logic [ST_W-1:0] ST_DONE = 2'd2;

    localparam logic [PAT_W-1:0] PATTERN_RST = 8'b0000_0001;

    // dir=0 rotates toward the MSB, dir=1 toward the LSB
    function automatic logic [PAT_W-1:0] ring_rotate(input logic [PAT_W-1:0] pat, input logic dir);
        if (dir) begin
            ring_rotate = {pat[0], pat[PAT_W-1:1]};
        end else begin
            ring_rotate = {pat[PAT_W-2:0], pat[PAT_W-1]};
        end
    endfunction

endpackage

// File: rtl/tick_ring_sequencer_if.sv
// Control/status bundle between a sequencer controller and the ring sequencer.
interface tick_ring_sequencer_if;
    import tick_ring_sequencer_pkg::*;

    logic              dclk;
    logic              start;
    logic              stop;
    logic              dir;
    logic              load;
    logic [PAT_W-1:0]  load_val;
    logic [CNT_W-1:0]  steps;
    logic [PAT_W-1:0]  pattern;
    logic [CNT_W-1:0]  step_cnt;
    logic              busy;
    logic              done;

    modport master (
        output dclk, start, stop, dir, load, load_val, steps,
        input  pattern, step_cnt, busy, done
    );

    modport slave (
        input  dclk, start, stop, dir, load, load_val, steps,
        output pattern, step_cnt, busy, done
    );

endinterface

// File: rtl/tick_ring_sequencer_edge_detect.sv
// Rising-edge detector: pulse is high in the cycle din is first sampled high.
module tick_edge_detect (
    input  logic clk,
    input  logic rst_n,
    input  logic din,
    output logic pulse
);

    logic din_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            din_q <= 1'b0;
        end else begin
            din_q <= din;
        end
    end

    // Combinational so the tick acts on the same edge that samples din high
    assign pulse = din & ~din_q;

endmodule

// File: rtl/tick_ring_sequencer.sv
// Ring-pattern sequencer advanced by divided-clock ticks; bounded or free-running runs.
module tick_ring_sequencer
    import tick_ring_sequencer_pkg::*;
(
    input  logic                        clk,
    input  logic                        rst_n,
    tick_ring_sequencer_if.slave        bus
);

    logic              tick;
    logic [ST_W-1:0]   state_q,   state_d;
    logic [PAT_W-1:0]  pattern_q, pattern_d;
    logic [CNT_W-1:0]  cnt_q,     cnt_d;
    logic [CNT_W-1:0]  steps_q,   steps_d;
    logic              busy_q;
    logic              done_q;
    logic [CNT_W-1:0]  cnt_inc;

    tick_edge_detect u_edge (
        .clk   (clk),
        .rst_n (rst_n),
        .din   (bus.dclk),
        .pulse (tick)
    );

    assign cnt_inc = CNT_W'(cnt_q + CNT_W'(1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            pattern_q <= PATTERN_RST;
            cnt_q     <= '0;
            steps_q   <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            pattern_q <= pattern_d;
            cnt_q     <= cnt_d;
            steps_q   <= steps_d;
            busy_q    <= (state_d == ST_RUN);
            done_q    <= (state_d == ST_DONE);
        end
    end

    // Next-state and datapath; stop has priority over a coincident tick
    always_comb begin
        state_d   = state_q;
        pattern_d = pattern_q;
        cnt_d     = cnt_q;
        steps_d   = steps_q;
        case (state_q)
            ST_IDLE: begin
                if (bus.load) begin
                    pattern_d = bus.load_val;
                end
                if (bus.start) begin
                    state_d = ST_RUN;
                    cnt_d   = '0;
                    steps_d = bus.steps;
                end
            end
            ST_RUN: begin
                if (bus.stop) begin
                    state_d = ST_IDLE;
                end else if (tick) begin
                    pattern_d = ring_rotate(pattern_q, bus.dir);
                    cnt_d     = cnt_inc;
                    if ((steps_q != '0) && (cnt_inc == steps_q)) begin
                        state_d = ST_DONE;
                    end
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    assign bus.pattern  = pattern_q;
    assign bus.step_cnt = cnt_q;
    assign bus.busy     = busy_q;
    assign bus.done     = done_q;

endmodule
